// File: rtl/fprint_writer.sv
// Purpose : Avalon-MM write master turning buffered fingerprint/task-end events into comparator register writes.
// Latency : event pushed at edge N into an empty FIFO -> first beat has write=1 after edge N+1, CRC beat (fingerprints) after edge N+2.
// Backpressure: in_ready drops while the FIFO is full; waitrequest=1 freezes address/data/write until the beat completes.
//
// Ports:
//   clk, reset             - single clock, synchronous active-low reset
//   in_valid/in_ready      - event handshake from the CRC engine
//   in_type                - 0 = fingerprint (task beat + CRC beat), 1 = task end (one beat)
//   in_task_id, in_crc     - event payload (in_crc unused for task-end events)
//   fprint_address/_write/_writedata/_waitrequest - Avalon-MM write master towards the comparator
//   busy                   - FIFO non-empty or a write sequence in progress
//   fifo_count             - number of buffered events
module fprint_writer #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int KEY_WIDTH   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TASK_OFFSET = 0,
    parameter int CRC_OFFSET  = 1,
    parameter int END_OFFSET  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_type,
    input  logic [KEY_WIDTH-1:0]        in_task_id,
    input  logic [DATA_WIDTH-1:0]       in_crc,
    output logic [ADDR_WIDTH-1:0]       fprint_address,
    output logic                        fprint_write,
    output logic [DATA_WIDTH-1:0]       fprint_writedata,
    input  logic                        fprint_waitrequest,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + KEY_WIDTH + DATA_WIDTH;

    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] A_TASK   = ADDR_WIDTH'(TASK_OFFSET);
    localparam logic [ADDR_WIDTH-1:0] A_CRC    = ADDR_WIDTH'(CRC_OFFSET);
    localparam logic [ADDR_WIDTH-1:0] A_END    = ADDR_WIDTH'(END_OFFSET);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_TASK = 2'd1,
        S_WR_CRC  = 2'd2,
        S_WR_END  = 2'd3
    } state_t;

    // Event buffer: {type, task_id, crc} per entry
    logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    // Write sequencer
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_crc;      // CRC held for the second beat of a fingerprint

    logic                  w_push;
    logic                  w_pop;
    logic                  w_done;
    logic [ENT_W-1:0]      w_head;
    logic                  w_head_type;
    logic [KEY_WIDTH-1:0]  w_head_task;
    logic [DATA_WIDTH-1:0] w_head_crc;

    assign in_ready    = (r_count != FULL_CNT);
    assign w_push      = in_valid & in_ready;
    // The head is only taken while the sequencer is idle, so an event's beats are never interleaved
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_done      = r_write & ~fprint_waitrequest;

    assign w_head      = r_mem[r_rptr];
    assign w_head_type = w_head[ENT_W-1];
    assign w_head_task = w_head[DATA_WIDTH +: KEY_WIDTH];
    assign w_head_crc  = w_head[DATA_WIDTH-1:0];

    assign fprint_address   = r_addr;
    assign fprint_write     = r_write;
    assign fprint_writedata = r_wdata;
    assign fifo_count       = r_count;
    assign busy             = (r_count != '0) || (r_state != S_IDLE);

    // Storage needs no reset: entries are only read below the occupancy count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_type, in_task_id, in_crc};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_crc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_crc   <= w_head_crc;
                        r_wdata <= DATA_WIDTH'(w_head_task);
                        r_write <= 1'b1;
                        if (w_head_type) begin
                            r_state <= S_WR_END;
                            r_addr  <= A_END;
                        end else begin
                            r_state <= S_WR_TASK;
                            r_addr  <= A_TASK;
                        end
                    end
                end
                S_WR_TASK: begin
                    // CRC beat follows the task beat with no gap
                    if (w_done) begin
                        r_state <= S_WR_CRC;
                        r_addr  <= A_CRC;
                        r_wdata <= r_crc;
                    end
                end
                S_WR_CRC, S_WR_END: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                        r_addr  <= '0;
                        r_wdata <= '0;
                        r_write <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
